// File: rtl/ccu_ctrl_pkg.sv
// Shared CCU control definitions.
//   - CRRESP bit positions used when merging snoop responses.
//   - merge_state_t: state encoding of the snoop fan-out/merge stage.
package ccu_ctrl_pkg;

    // CRRESP bit positions {WasUnique, IsShared, PassDirty, Error, DataTransfer}
    localparam int unsigned CR_DT = 0;
    localparam int unsigned CR_ERR = 1;
    localparam int unsigned CR_PD = 2;
    localparam int unsigned CR_IS = 3;
    localparam int unsigned CR_WU = 4;
    localparam int unsigned CR_W = 5;

    typedef enum logic [1:0] {
        MERGE_IDLE   = 2'd0,
        MERGE_SNOOP  = 2'd1,
        MERGE_CR_OUT = 2'd2,
        MERGE_CD     = 2'd3
    } merge_state_t;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter.
//   in_i    : input vector
//   cnt_o   : MODE=0 -> index of lowest set bit, MODE=1 -> number of leading zeros
//   empty_o : no bit of in_i is set (cnt_o is then 0)
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    // Scan from the top down so that the lowest matching position wins.
    always_comb begin
        cnt_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (MODE == 1'b0) begin
                if (in_i[i]) begin
                    cnt_o = CNT_WIDTH'(i);
                end else begin
                    cnt_o = cnt_o;
                end
            end else begin
                if (in_i[WIDTH-1-i]) begin
                    cnt_o = CNT_WIDTH'(i);
                end else begin
                    cnt_o = cnt_o;
                end
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/ccu_snoop_merge.sv
// Snoop fan-out/merge stage.
// Accepts one AC request with a domain mask, broadcasts it to every selected
// cached master, OR-merges their CR responses into one upstream CR, then
// forwards exactly one CD burst upstream while draining the CD bursts of any
// other master that signalled DataTransfer.
//   ac_*            : upstream snoop request (valid/ready, addr, snoop, prot)
//   domain_mask_i   : masters to snoop, sampled with the AC handshake
//   cr_*            : merged snoop response to upstream
//   cd_*            : forwarded snoop data to upstream (combinational path)
//   mst_ac_*        : per-master AC valid/ready, shared latched payload
//   mst_cr_*        : per-master CR handshake and response
//   mst_cd_*        : per-master CD handshake, data and last
module ccu_snoop_merge
    import ccu_ctrl_pkg::*;
#(
    parameter int unsigned NoMst     = 2,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       ac_valid_i,
    output logic                       ac_ready_o,
    input  logic [AddrWidth-1:0]       ac_addr_i,
    input  logic [3:0]                 ac_snoop_i,
    input  logic [2:0]                 ac_prot_i,
    input  logic [NoMst-1:0]           domain_mask_i,
    output logic                       cr_valid_o,
    input  logic                       cr_ready_i,
    output logic [4:0]                 cr_resp_o,
    output logic                       cd_valid_o,
    input  logic                       cd_ready_i,
    output logic [DataWidth-1:0]       cd_data_o,
    output logic                       cd_last_o,
    output logic [NoMst-1:0]           mst_ac_valid_o,
    input  logic [NoMst-1:0]           mst_ac_ready_i,
    output logic [AddrWidth-1:0]       mst_ac_addr_o,
    output logic [3:0]                 mst_ac_snoop_o,
    output logic [2:0]                 mst_ac_prot_o,
    input  logic [NoMst-1:0]           mst_cr_valid_i,
    output logic [NoMst-1:0]           mst_cr_ready_o,
    input  logic [5*NoMst-1:0]         mst_cr_resp_i,
    input  logic [NoMst-1:0]           mst_cd_valid_i,
    output logic [NoMst-1:0]           mst_cd_ready_o,
    input  logic [DataWidth*NoMst-1:0] mst_cd_data_i,
    input  logic [NoMst-1:0]           mst_cd_last_i
);

    localparam int unsigned SrcW = (NoMst > 1) ? $clog2(NoMst) : 1;

    merge_state_t         state_r, state_s;
    logic [AddrWidth-1:0] addr_r;
    logic [3:0]           snoop_r;
    logic [2:0]           prot_r;
    logic [NoMst-1:0]     mask_r;
    logic [NoMst-1:0]     ac_pend_r, ac_pend_s;
    logic [NoMst-1:0]     cr_got_r, cr_got_s;
    logic [NoMst-1:0]     dt_mask_r, dt_mask_s;
    logic [NoMst-1:0]     pd_mask_r, pd_mask_s;
    logic [NoMst-1:0]     cd_done_r, cd_done_s;
    logic [CR_W-1:0]      resp_acc_r, resp_acc_s;
    logic [SrcW-1:0]      src_r, src_s;
    logic                 latch_s;

    logic [NoMst-1:0]     ac_hs_s;
    logic [NoMst-1:0]     cr_ready_s;
    logic [NoMst-1:0]     cr_hs_s;
    logic [NoMst-1:0]     cd_ready_s;
    logic [NoMst-1:0]     cd_last_hs_s;
    logic [CR_W-1:0]      resp_in_s;
    logic [NoMst-1:0]     dt_new_s;
    logic [NoMst-1:0]     pd_new_s;
    logic [NoMst-1:0]     lzc_in_s;
    logic [SrcW-1:0]      lzc_cnt_s;
    logic                 lzc_empty_s;
    logic [DataWidth-1:0] src_data_s;
    logic                 src_last_s;
    logic                 src_valid_s;
    logic                 src_done_s;

    // Prefer a dirty-passing data source; otherwise any data-transferring master.
    assign lzc_in_s = (|(dt_mask_r & pd_mask_r)) ? (dt_mask_r & pd_mask_r) : dt_mask_r;

    lzc #(
        .WIDTH     (NoMst),
        .MODE      (1'b0),
        .CNT_WIDTH (SrcW)
    ) i_src_lzc (
        .in_i    (lzc_in_s),
        .cnt_o   (lzc_cnt_s),
        .empty_o (lzc_empty_s)
    );

    // Per-master handshakes. CR is only accepted after that master's AC has
    // completed in an earlier cycle, hence the registered ac_pend_r term.
    assign ac_hs_s      = mst_ac_valid_o & mst_ac_ready_i;
    assign cr_ready_s   = (state_r == MERGE_SNOOP) ? (mask_r & ~ac_pend_r & ~cr_got_r) : '0;
    assign cr_hs_s      = cr_ready_s & mst_cr_valid_i;
    assign cd_last_hs_s = cd_ready_s & mst_cd_valid_i & mst_cd_last_i;

    // OR-merge of all CR responses accepted this cycle.
    always_comb begin
        resp_in_s = '0;
        dt_new_s  = '0;
        pd_new_s  = '0;
        for (int i = 0; i < NoMst; i++) begin
            if (cr_hs_s[i]) begin
                resp_in_s   = resp_in_s | mst_cr_resp_i[i*CR_W +: CR_W];
                dt_new_s[i] = mst_cr_resp_i[i*CR_W + CR_DT];
                pd_new_s[i] = mst_cr_resp_i[i*CR_W + CR_DT] & mst_cr_resp_i[i*CR_W + CR_PD];
            end else begin
                dt_new_s[i] = 1'b0;
                pd_new_s[i] = 1'b0;
            end
        end
    end

    // Selected source mux for the CD pass-through.
    always_comb begin
        src_data_s  = '0;
        src_last_s  = 1'b0;
        src_valid_s = 1'b0;
        src_done_s  = 1'b0;
        for (int i = 0; i < NoMst; i++) begin
            if (SrcW'(i) == src_r) begin
                src_data_s  = mst_cd_data_i[i*DataWidth +: DataWidth];
                src_last_s  = mst_cd_last_i[i];
                src_valid_s = mst_cd_valid_i[i];
                src_done_s  = cd_done_r[i];
            end else begin
                src_data_s  = src_data_s;
            end
        end
    end

    // CD ready: source follows upstream, other data masters drain freely.
    always_comb begin
        cd_ready_s = '0;
        for (int i = 0; i < NoMst; i++) begin
            if ((state_r == MERGE_CD) && dt_mask_r[i] && !cd_done_r[i]) begin
                if (SrcW'(i) == src_r) begin
                    cd_ready_s[i] = cd_ready_i;
                end else begin
                    cd_ready_s[i] = 1'b1;
                end
            end else begin
                cd_ready_s[i] = 1'b0;
            end
        end
    end

    // Next-state and bookkeeping logic.
    always_comb begin
        state_s    = state_r;
        ac_pend_s  = ac_pend_r;
        cr_got_s   = cr_got_r;
        resp_acc_s = resp_acc_r;
        dt_mask_s  = dt_mask_r;
        pd_mask_s  = pd_mask_r;
        cd_done_s  = cd_done_r;
        src_s      = src_r;
        latch_s    = 1'b0;
        case (state_r)
            MERGE_IDLE: begin
                if (ac_valid_i) begin
                    latch_s    = 1'b1;
                    ac_pend_s  = domain_mask_i;
                    cr_got_s   = '0;
                    resp_acc_s = '0;
                    dt_mask_s  = '0;
                    pd_mask_s  = '0;
                    cd_done_s  = '0;
                    if (domain_mask_i == '0) begin
                        state_s = MERGE_CR_OUT;
                    end else begin
                        state_s = MERGE_SNOOP;
                    end
                end else begin
                    state_s = MERGE_IDLE;
                end
            end
            MERGE_SNOOP: begin
                ac_pend_s  = ac_pend_r & ~ac_hs_s;
                cr_got_s   = cr_got_r | cr_hs_s;
                resp_acc_s = resp_acc_r | resp_in_s;
                dt_mask_s  = dt_mask_r | dt_new_s;
                pd_mask_s  = pd_mask_r | pd_new_s;
                if ((cr_got_r | cr_hs_s) == mask_r) begin
                    state_s = MERGE_CR_OUT;
                end else begin
                    state_s = MERGE_SNOOP;
                end
            end
            MERGE_CR_OUT: begin
                if (cr_ready_i) begin
                    src_s = lzc_cnt_s;
                    if (lzc_empty_s) begin
                        state_s = MERGE_IDLE;
                    end else begin
                        state_s = MERGE_CD;
                    end
                end else begin
                    state_s = MERGE_CR_OUT;
                end
            end
            MERGE_CD: begin
                cd_done_s = cd_done_r | cd_last_hs_s;
                if ((cd_done_r | cd_last_hs_s) == dt_mask_r) begin
                    state_s = MERGE_IDLE;
                end else begin
                    state_s = MERGE_CD;
                end
            end
            default: begin
                state_s = MERGE_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= MERGE_IDLE;
            ac_pend_r  <= '0;
            cr_got_r   <= '0;
            resp_acc_r <= '0;
            dt_mask_r  <= '0;
            pd_mask_r  <= '0;
            cd_done_r  <= '0;
            src_r      <= '0;
        end else begin
            state_r    <= state_s;
            ac_pend_r  <= ac_pend_s;
            cr_got_r   <= cr_got_s;
            resp_acc_r <= resp_acc_s;
            dt_mask_r  <= dt_mask_s;
            pd_mask_r  <= pd_mask_s;
            cd_done_r  <= cd_done_s;
            src_r      <= src_s;
        end
    end

    // Latched AC payload and domain mask.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_r  <= '0;
            snoop_r <= '0;
            prot_r  <= '0;
            mask_r  <= '0;
        end else if (latch_s) begin
            addr_r  <= ac_addr_i;
            snoop_r <= ac_snoop_i;
            prot_r  <= ac_prot_i;
            mask_r  <= domain_mask_i;
        end else begin
            addr_r  <= addr_r;
        end
    end

    assign ac_ready_o     = (state_r == MERGE_IDLE);
    assign mst_ac_valid_o = (state_r == MERGE_SNOOP) ? ac_pend_r : '0;
    assign mst_ac_addr_o  = addr_r;
    assign mst_ac_snoop_o = snoop_r;
    assign mst_ac_prot_o  = prot_r;
    assign mst_cr_ready_o = cr_ready_s;
    assign mst_cd_ready_o = cd_ready_s;

    assign cr_valid_o = (state_r == MERGE_CR_OUT);
    assign cr_resp_o  = (state_r == MERGE_CR_OUT) ? resp_acc_r : '0;

    // Once the source has delivered its last beat, upstream sees no more valid
    // while the remaining drains complete.
    assign cd_valid_o = (state_r == MERGE_CD) & src_valid_s & ~src_done_s;
    assign cd_data_o  = (state_r == MERGE_CD) ? src_data_s : '0;
    assign cd_last_o  = (state_r == MERGE_CD) & src_last_s;

endmodule

// File: tb/tb_ccu_snoop_merge.sv
// Self-checking bench for ccu_snoop_merge (NoMst=2): directed vector table,
// mid-burst reset, then randomized transactions against a response model.
module tb_ccu_snoop_merge;

    localparam int N  = 2;
    localparam int AW = 64;
    localparam int DW = 64;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            ac_valid_i, ac_ready_o;
    logic [AW-1:0]   ac_addr_i;
    logic [3:0]      ac_snoop_i;
    logic [2:0]      ac_prot_i;
    logic [N-1:0]    domain_mask_i;
    logic            cr_valid_o, cr_ready_i;
    logic [4:0]      cr_resp_o;
    logic            cd_valid_o, cd_ready_i;
    logic [DW-1:0]   cd_data_o;
    logic            cd_last_o;
    logic [N-1:0]    mst_ac_valid_o, mst_ac_ready_i;
    logic [AW-1:0]   mst_ac_addr_o;
    logic [3:0]      mst_ac_snoop_o;
    logic [2:0]      mst_ac_prot_o;
    logic [N-1:0]    mst_cr_valid_i, mst_cr_ready_o;
    logic [5*N-1:0]  mst_cr_resp_i;
    logic [N-1:0]    mst_cd_valid_i, mst_cd_ready_o;
    logic [DW*N-1:0] mst_cd_data_i;
    logic [N-1:0]    mst_cd_last_i;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    ccu_snoop_merge #(.NoMst(N), .AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
        .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i), .domain_mask_i(domain_mask_i),
        .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
        .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o),
        .cd_last_o(cd_last_o),
        .mst_ac_valid_o(mst_ac_valid_o), .mst_ac_ready_i(mst_ac_ready_i),
        .mst_ac_addr_o(mst_ac_addr_o), .mst_ac_snoop_o(mst_ac_snoop_o),
        .mst_ac_prot_o(mst_ac_prot_o),
        .mst_cr_valid_i(mst_cr_valid_i), .mst_cr_ready_o(mst_cr_ready_o),
        .mst_cr_resp_i(mst_cr_resp_i),
        .mst_cd_valid_i(mst_cd_valid_i), .mst_cd_ready_o(mst_cd_ready_o),
        .mst_cd_data_i(mst_cd_data_i), .mst_cd_last_i(mst_cd_last_i)
    );

    typedef struct {
        logic [1:0] mask;
        logic [4:0] r0, r1;
        int         d0, d1;      // cycles each master holds AC ready low
        int         b0, b1;      // CD beats each master sends
        int         cdm;         // 0 ready, 1 toggle, 2 random upstream cd_ready
        int         crd;         // cycles upstream holds cr_ready low
        int         rstb;        // >0: reset while presenting this upstream beat
        logic [4:0] exp_resp;
        int         exp_src;
        int         exp_beats;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] beat_data(input int txn, input int m, input int b);
        return {32'(txn), 16'(m), 16'(b)};
    endfunction

    function automatic vec_t mk(input logic [1:0] mask, input logic [4:0] r0, input logic [4:0] r1,
                                input int d0, input int d1, input int b0, input int b1,
                                input int cdm, input int crd, input int rstb,
                                input logic [4:0] er, input int es, input int eb);
        vec_t v;
        v.mask = mask; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1;
        v.cdm = cdm; v.crd = crd; v.rstb = rstb; v.exp_resp = er; v.exp_src = es; v.exp_beats = eb;
        return v;
    endfunction

    // Reference: merged CR is the OR of snooped responses; the data source is the
    // lowest dirty data master, else the lowest data master.
    function automatic vec_t model(input vec_t v);
        vec_t o;
        logic [4:0] r [2];
        int b [2];
        int src;
        o = v; r[0] = v.r0; r[1] = v.r1; b[0] = v.b0; b[1] = v.b1; src = -1;
        o.exp_resp = 5'b0;
        for (int i = 0; i < N; i++) if (v.mask[i]) o.exp_resp = o.exp_resp | r[i];
        for (int i = 0; i < N; i++) if (src < 0 && v.mask[i] && r[i][0] && r[i][2]) src = i;
        for (int i = 0; i < N; i++) if (src < 0 && v.mask[i] && r[i][0]) src = i;
        o.exp_src   = (src < 0) ? 0 : src;
        o.exp_beats = (src < 0) ? 0 : b[src];
        return o;
    endfunction

    task automatic idle_inputs();
        ac_valid_i = 1'b0; ac_addr_i = '0; ac_snoop_i = 4'h0; ac_prot_i = 3'h0;
        domain_mask_i = '0; cr_ready_i = 1'b0; cd_ready_i = 1'b0;
        mst_ac_ready_i = '0; mst_cr_valid_i = '0; mst_cr_resp_i = '0;
        mst_cd_valid_i = '0; mst_cd_data_i = '0; mst_cd_last_i = '0;
    endtask

    // Assert reset mid-cycle; optionally check that every handshake output drops.
    task automatic do_reset(input bit check);
        rst_ni = 1'b0;
        #1;
        if (check) begin
            chk("rst_mst_ac_valid", 64'(mst_ac_valid_o), 64'd0);
            chk("rst_mst_cr_ready", 64'(mst_cr_ready_o), 64'd0);
            chk("rst_mst_cd_ready", 64'(mst_cd_ready_o), 64'd0);
            chk("rst_cr_valid", 64'(cr_valid_o), 64'd0);
            chk("rst_cd_valid", 64'(cd_valid_o), 64'd0);
            chk("rst_ac_ready", 64'(ac_ready_o), 64'd1);
        end
        idle_inputs();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic run_txn(input vec_t v, input int txn);
        logic [4:0] r [2];
        int dly [2];
        int nb [2];
        int bm [2];
        bit ac_done [2];
        bit cr_done [2];
        bit seen_acv [2];
        bit acc, crhs, fin, seen_crv;
        int cyc, ac_cyc, last_cr, crv_cnt, up;
        logic [AW-1:0] addr;
        r[0] = v.r0; r[1] = v.r1; dly[0] = v.d0; dly[1] = v.d1; nb[0] = v.b0; nb[1] = v.b1;
        for (int i = 0; i < N; i++) begin
            bm[i] = 0; ac_done[i] = 1'b0; cr_done[i] = 1'b0; seen_acv[i] = 1'b0;
        end
        acc = 1'b0; crhs = 1'b0; fin = 1'b0; seen_crv = 1'b0;
        cyc = 0; ac_cyc = 0; last_cr = -1; crv_cnt = 0; up = 0;
        addr = {$urandom, $urandom};
        while (!fin && cyc < 300) begin
            @(negedge clk_i);
            ac_valid_i = !acc; ac_addr_i = addr; ac_snoop_i = 4'(txn); ac_prot_i = 3'(txn);
            domain_mask_i = v.mask;
            for (int i = 0; i < N; i++) begin
                mst_ac_ready_i[i] = acc && (cyc > ac_cyc + dly[i]);
                mst_cr_valid_i[i] = ac_done[i] && !cr_done[i];
                mst_cr_resp_i[i*5 +: 5] = r[i];
                mst_cd_valid_i[i] = cr_done[i] && r[i][0] && (bm[i] < nb[i]);
                mst_cd_data_i[i*DW +: DW] = beat_data(txn, i, bm[i]);
                mst_cd_last_i[i] = (bm[i] == nb[i] - 1);
            end
            cr_ready_i = cr_valid_o && (crv_cnt >= v.crd);
            case (v.cdm)
                1:       cd_ready_i = ((cyc % 2) == 0);
                2:       cd_ready_i = 1'($urandom_range(0, 1));
                default: cd_ready_i = 1'b1;
            endcase
            #1;
            if (cyc == 0) chk("ac_ready_first_cycle", 64'(ac_ready_o), 64'd1);
            for (int i = 0; i < N; i++) begin
                if (!v.mask[i])
                    chk("unmasked_quiet", 64'({mst_ac_valid_o[i], mst_cr_ready_o[i], mst_cd_ready_o[i]}), 64'd0);
                if (!ac_done[i]) chk("cr_before_ac", 64'(mst_cr_ready_o[i]), 64'd0);
                if (ac_done[i]) chk("ac_valid_after_hs", 64'(mst_ac_valid_o[i]), 64'd0);
                if (mst_ac_valid_o[i] && !seen_acv[i]) begin
                    seen_acv[i] = 1'b1;
                    chk("ac_fanout_latency", 64'(cyc), 64'(ac_cyc + 1));
                    chk("ac_addr_fwd", mst_ac_addr_o, addr);
                end
            end
            if (cr_valid_o) begin
                if (!seen_crv) begin
                    seen_crv = 1'b1;
                    chk("cr_latency", 64'(cyc), 64'(((last_cr > ac_cyc) ? last_cr : ac_cyc) + 1));
                end
                chk("cr_resp", 64'(cr_resp_o), 64'(v.exp_resp));
                chk("ac_blocked_in_cr", 64'(ac_ready_o), 64'd0);
            end
            if (v.rstb > 0 && crhs && up == v.rstb - 1 && cd_valid_o) begin
                do_reset(1'b1);
                return;
            end
            if (cd_valid_o && cd_ready_i) begin
                chk("cd_data", cd_data_o, beat_data(txn, v.exp_src, up));
                chk("cd_last", 64'(cd_last_o), 64'(up == v.exp_beats - 1));
                up++;
            end
            if (ac_valid_i && ac_ready_o && !acc) begin
                acc = 1'b1; ac_cyc = cyc;
            end
            for (int i = 0; i < N; i++) begin
                if (mst_ac_valid_o[i] && mst_ac_ready_i[i]) ac_done[i] = 1'b1;
                if (mst_cr_valid_i[i] && mst_cr_ready_o[i]) begin
                    cr_done[i] = 1'b1; last_cr = cyc;
                end
                if (mst_cd_valid_i[i] && mst_cd_ready_o[i]) bm[i]++;
            end
            if (cr_valid_o) crv_cnt++;
            if (cr_valid_o && cr_ready_i) crhs = 1'b1;
            if (crhs) begin
                fin = 1'b1;
                for (int i = 0; i < N; i++)
                    if (v.mask[i] && r[i][0] && bm[i] < nb[i]) fin = 1'b0;
            end
            cyc++;
        end
        chk("txn_completes", 64'(fin), 64'd1);
        if (fin) begin
            chk("cd_beat_count", 64'(up), 64'(v.exp_beats));
        end else begin
            do_reset(1'b0);
        end
    endtask

    vec_t tbl [8];
    vec_t rv;

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        tbl[0] = mk(2'b00, 5'b00000, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0);
        tbl[1] = mk(2'b11, 5'b00000, 5'b00000, 0, 3, 0, 0, 0, 0, 0, 5'b00000, 0, 0);
        tbl[2] = mk(2'b11, 5'b01001, 5'b00101, 0, 0, 4, 4, 0, 0, 0, 5'b01101, 1, 4);
        tbl[3] = mk(2'b01, 5'b00011, 5'b00000, 1, 0, 2, 0, 1, 0, 0, 5'b00011, 0, 2);
        tbl[4] = mk(2'b10, 5'b00000, 5'b10000, 0, 1, 0, 0, 0, 5, 0, 5'b10000, 0, 0);
        tbl[5] = mk(2'b11, 5'b00001, 5'b00001, 0, 0, 3, 3, 0, 0, 2, 5'b00001, 0, 3);
        tbl[6] = mk(2'b01, 5'b01000, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 5'b01000, 0, 0);
        tbl[7] = mk(2'b11, 5'b00101, 5'b00101, 2, 0, 2, 3, 2, 1, 0, 5'b00101, 0, 2);

        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_ac_ready", 64'(ac_ready_o), 64'd1);
        chk("reset_cr_valid", 64'(cr_valid_o), 64'd0);
        chk("reset_cr_resp", 64'(cr_resp_o), 64'd0);
        chk("reset_cd_valid", 64'(cd_valid_o), 64'd0);
        chk("reset_mst_ready_valid", 64'({mst_ac_valid_o, mst_cr_ready_o, mst_cd_ready_o}), 64'd0);
        chk("reset_latched_addr", mst_ac_addr_o, 64'd0);
        rst_ni = 1'b1;

        for (int k = 0; k < 8; k++) run_txn(tbl[k], k + 1);

        for (int k = 0; k < 40; k++) begin
            rv.mask = 2'($urandom_range(0, 3));
            rv.r0 = 5'($urandom); rv.r1 = 5'($urandom);
            rv.d0 = $urandom_range(0, 3); rv.d1 = $urandom_range(0, 3);
            rv.b0 = rv.r0[0] ? $urandom_range(1, 4) : 0;
            rv.b1 = rv.r1[0] ? $urandom_range(1, 4) : 0;
            rv.cdm = $urandom_range(0, 2); rv.crd = $urandom_range(0, 2); rv.rstb = 0;
            rv = model(rv);
            run_txn(rv, 100 + k);
        end

        @(negedge clk_i);
        #1;
        chk("final_idle", 64'(ac_ready_o), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
